// File: rtl/game_sequencer.sv
// Top-level game flow controller: sequences IDLE -> START -> PLAY with HIT and
// NEXT_LEVEL pauses, and keeps score, lives and level for the display path.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// IDLE       | power-up wait; only start_pulse is honoured
// START      | one-cycle datapath clear (new game, or resume after a pause)
// PLAY       | game running; kills score, hit/wave_clear/invaded leave
// HIT        | PAUSE_TICKS dwell after the player is struck
// NEXT_LEVEL | PAUSE_TICKS dwell after a wave is cleared
// GAME_OVER  | final score shown; start_pulse begins a new game
module game_sequencer #(
  parameter int INIT_LIVES  = 3,
  parameter int PAUSE_TICKS = 100_000_000,
  parameter int KILL_POINTS = 10
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        start_pulse,
  input  logic        alien_kill,
  input  logic        player_hit,
  input  logic        wave_clear,
  input  logic        invaded,
  output logic        game_run,
  output logic        logic_clear,
  output logic [2:0]  state,
  output logic [13:0] score,
  output logic [1:0]  lives,
  output logic [3:0]  level
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_START      = 3'd1,
    S_PLAY       = 3'd2,
    S_HIT        = 3'd3,
    S_NEXT_LEVEL = 3'd4,
    S_GAME_OVER  = 3'd5
  } state_t;

  localparam logic [31:0] PAUSE_LOAD = 32'(PAUSE_TICKS - 1);
  localparam logic [31:0] SCORE_MAX  = 32'd9999;

  state_t      state_q, state_d;
  logic [13:0] score_q, score_d;
  logic [1:0]  lives_q, lives_d;
  logic [3:0]  level_q, level_d;
  logic [31:0] pause_q, pause_d;
  logic [31:0] score_sum;
  logic        game_run_q, logic_clear_q;

  // Next-state and bookkeeping updates; every register holds unless changed.
  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    lives_d   = lives_q;
    level_d   = level_q;
    pause_d   = pause_q;
    score_sum = {18'd0, score_q} + 32'(KILL_POINTS);
    case (state_q)
      S_IDLE, S_GAME_OVER: begin
        if (start_pulse) begin
          state_d = S_START;
          score_d = '0;
          lives_d = 2'(INIT_LIVES);
          level_d = '0;
        end
      end
      S_START: state_d = S_PLAY;
      S_PLAY: begin
        // A kill on the same edge as a transition still counts.
        if (alien_kill) begin
          score_d = (score_sum > SCORE_MAX) ? 14'd9999 : score_sum[13:0];
        end
        if (invaded) begin
          state_d = S_GAME_OVER;
          lives_d = '0;
        end else if (player_hit) begin
          state_d = S_HIT;
          pause_d = PAUSE_LOAD;
          if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
        end else if (wave_clear) begin
          state_d = S_NEXT_LEVEL;
          pause_d = PAUSE_LOAD;
        end
      end
      S_HIT: begin
        if (pause_q == 32'd0) begin
          state_d = (lives_q == 2'd0) ? S_GAME_OVER : S_START;
        end else begin
          pause_d = pause_q - 32'd1;
        end
      end
      S_NEXT_LEVEL: begin
        if (pause_q == 32'd0) begin
          state_d = S_START;
          if (level_q != 4'd15) level_d = level_q + 4'd1;
        end else begin
          pause_d = pause_q - 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and registered strobes; Reset overrides everything.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      score_q       <= '0;
      lives_q       <= '0;
      level_q       <= '0;
      pause_q       <= '0;
      game_run_q    <= 1'b0;
      logic_clear_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      score_q       <= score_d;
      lives_q       <= lives_d;
      level_q       <= level_d;
      pause_q       <= pause_d;
      game_run_q    <= (state_d == S_PLAY);
      logic_clear_q <= (state_d == S_START);
    end
  end

  assign state       = state_q;
  assign score       = score_q;
  assign lives       = lives_q;
  assign level       = level_q;
  assign game_run    = game_run_q;
  assign logic_clear = logic_clear_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed scenarios plus random play, with every
// cycle compared against a behavioural model of the game rules.
module tb_game_sequencer;

  localparam int PT = 4;
  localparam int IL = 3;
  localparam int KP = 10;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start_pulse = 1'b0, alien_kill = 1'b0, player_hit = 1'b0;
  logic        wave_clear = 1'b0, invaded = 1'b0;
  logic        game_run, logic_clear;
  logic [2:0]  state;
  logic [13:0] score;
  logic [1:0]  lives;
  logic [3:0]  level;

  int tests = 0;
  int fails = 0;

  // Model: game phase codes, score/lives/level and cycles spent in a pause.
  int m_phase = 0, m_score = 0, m_lives = 0, m_level = 0, m_dwell = 0;
  bit m_valid = 0;

  game_sequencer #(.INIT_LIVES(IL), .PAUSE_TICKS(PT), .KILL_POINTS(KP)) dut (
    .clk(clk), .Reset(Reset), .start_pulse(start_pulse), .alien_kill(alien_kill),
    .player_hit(player_hit), .wave_clear(wave_clear), .invaded(invaded),
    .game_run(game_run), .logic_clear(logic_clear), .state(state),
    .score(score), .lives(lives), .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference, advanced once per rising edge.
  always @(posedge clk) begin : mdl
    int p, sc, lv, lvl, dw;
    p = m_phase; sc = m_score; lv = m_lives; lvl = m_level; dw = m_dwell;
    if (Reset) begin
      p = 0; sc = 0; lv = 0; lvl = 0; dw = 0;
    end else if (p == 0 || p == 5) begin
      if (start_pulse) begin p = 1; sc = 0; lv = IL; lvl = 0; end
    end else if (p == 1) begin
      p = 2;
    end else if (p == 2) begin
      if (alien_kill) sc = (sc + KP > 9999) ? 9999 : sc + KP;
      if (invaded) begin p = 5; lv = 0; end
      else if (player_hit) begin p = 3; lv = (lv > 0) ? lv - 1 : 0; dw = 0; end
      else if (wave_clear) begin p = 4; dw = 0; end
    end else begin
      dw = dw + 1;
      if (dw == PT) begin
        if (p == 3) p = (lv == 0) ? 5 : 1;
        else begin lvl = (lvl < 15) ? lvl + 1 : 15; p = 1; end
      end
    end
    m_phase <= p; m_score <= sc; m_lives <= lv; m_level <= lvl; m_dwell <= dw;
    m_valid <= 1'b1;
  end

  // Every-cycle comparison, away from the rising edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("state", int'(state), m_phase);
      chk("score", int'(score), m_score);
      chk("lives", int'(lives), m_lives);
      chk("level", int'(level), m_level);
      chk("game_run", int'(game_run), int'(m_phase == 2));
      chk("logic_clear", int'(logic_clear), int'(m_phase == 1));
    end
  end

  // One clock: drive inputs just after a falling edge, return at the next one.
  task automatic cyc(input bit sp, input bit ak, input bit ph, input bit wc,
                     input bit inv, input bit rst);
    start_pulse = sp; alien_kill = ak; player_hit = ph;
    wave_clear = wc; invaded = inv; Reset = rst;
    @(negedge clk);
    start_pulse = 0; alien_kill = 0; player_hit = 0;
    wave_clear = 0; invaded = 0; Reset = 0;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0);
  endtask

  // Advance until back in PLAY, bounded; an expired bound is reported.
  task automatic wait_play(input string name);
    int n = 0;
    while (state != 3'd2 && n < 50) begin idle(); n++; end
    chk({name, "_reach_play"}, int'(state), 2);
  endtask

  initial begin
    int n;
    @(negedge clk);
    cyc(0, 0, 0, 0, 0, 1);
    chk("rst_state", int'(state), 0);
    chk("rst_lives", int'(lives), 0);
    // Inputs other than start are ignored in IDLE; outputs hold reset values.
    cyc(0, 1, 1, 1, 1, 0);
    chk("idle_ign_state", int'(state), 0);
    chk("idle_ign_score", int'(score), 0);

    // Start: one START cycle with clear, then PLAY.
    cyc(1, 0, 0, 0, 0, 0);
    chk("start_state", int'(state), 1);
    chk("start_lc", int'(logic_clear), 1);
    chk("start_lives", int'(lives), 3);
    chk("start_score", int'(score), 0);
    cyc(1, 0, 0, 0, 0, 0);   // start ignored outside IDLE/GAME_OVER
    chk("play_state", int'(state), 2);
    chk("play_run", int'(game_run), 1);
    chk("play_lc", int'(logic_clear), 0);

    // Three kills, then hit+kill together.
    repeat (3) cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    chk("hit_score", int'(score), 40);
    chk("hit_lives", int'(lives), 2);
    chk("hit_state", int'(state), 3);
    n = 1;
    for (int i = 0; i < 20; i++) begin
      idle();
      if (state == 3'd3) n++;
      else break;
    end
    chk("hit_dwell", n, 4);
    chk("resume_state", int'(state), 1);
    chk("resume_lc", int'(logic_clear), 1);
    idle();
    chk("resume_play", int'(state), 2);

    // Two more hits: the last pause ends in GAME_OVER without a clear.
    cyc(0, 0, 1, 0, 0, 0);
    wait_play("hit2");
    cyc(0, 0, 1, 0, 0, 0);
    repeat (PT) idle();
    chk("over_state", int'(state), 5);
    chk("over_lives", int'(lives), 0);
    chk("over_lc", int'(logic_clear), 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("restart_state", int'(state), 1);
    chk("restart_score", int'(score), 0);
    chk("restart_lives", int'(lives), 3);
    idle();

    // One level, then invaded+hit+wave_clear together.
    cyc(0, 0, 0, 1, 0, 0);
    wait_play("lvl1");
    chk("lvl1", int'(level), 1);
    cyc(0, 0, 1, 1, 1, 0);
    chk("inv_state", int'(state), 5);
    chk("inv_lives", int'(lives), 0);
    chk("inv_level", int'(level), 1);

    // Sixteen cleared waves saturate the level; kills saturate the score.
    cyc(1, 0, 0, 0, 0, 0);
    idle();
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 0, 1, 0, 0);
      wait_play("wave");
    end
    chk("level_sat", int'(level), 15);
    repeat (999) cyc(0, 1, 0, 0, 0, 0);
    chk("score_9990", int'(score), 9990);
    cyc(0, 1, 0, 0, 0, 0);
    chk("score_sat", int'(score), 9999);
    cyc(0, 1, 0, 0, 0, 0);
    chk("score_hold", int'(score), 9999);

    // Reset on the second cycle of HIT.
    cyc(0, 0, 1, 0, 0, 0);
    idle();
    cyc(0, 0, 0, 0, 0, 1);
    chk("midrst_state", int'(state), 0);
    chk("midrst_score", int'(score), 0);
    chk("midrst_level", int'(level), 0);
    chk("midrst_run", int'(game_run), 0);
    repeat (3) idle();
    chk("hold_lives", int'(lives), 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("rst_restart", int'(state), 1);
    idle();
    chk("rst_restart_run", int'(game_run), 1);

    // Random play against the model.
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 29) == 0, $urandom_range(0, 39) == 0,
          $urandom_range(0, 119) == 0, $urandom_range(0, 299) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
